// File: rtl/circle_interp_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : circle_interp_gen_if
//  Brief    : Command/step-pulse bundle of the circular interpolator.
//  Revision : 1.0
// ============================================================================
interface circle_interp_gen_if #(
    parameter int COORD_W = 16,
    parameter int DIV_W   = 8
);
    logic                      start;
    logic                      direct;
    logic                      abort;
    logic signed [COORD_W-1:0] Xs;
    logic signed [COORD_W-1:0] Ys;
    logic signed [COORD_W-1:0] Xe;
    logic signed [COORD_W-1:0] Ye;
    logic [DIV_W-1:0]          div;
    logic                      X_acc;
    logic                      X_dec;
    logic                      Y_acc;
    logic                      Y_dec;
    logic                      busy;
    logic                      draw_overH;
    logic [1:0]                done_status;
    logic [COORD_W+2:0]        step_cnt;

    modport master (
        output start, direct, abort, Xs, Ys, Xe, Ye, div,
        input  X_acc, X_dec, Y_acc, Y_dec, busy, draw_overH, done_status, step_cnt
    );
    modport slave (
        input  start, direct, abort, Xs, Ys, Xe, Ye, div,
        output X_acc, X_dec, Y_acc, Y_dec, busy, draw_overH, done_status, step_cnt
    );
endinterface
`default_nettype wire

// File: rtl/circle_interp_gen.sv
`default_nettype none
// ============================================================================
//  Module   : circle_interp_gen
//  Brief    : Midpoint-style circular arc interpolator emitting axis step pulses.
//  Revision : 1.0
// ============================================================================
module circle_interp_gen #(
    parameter int COORD_W = 16,
    parameter int DIV_W   = 8
) (
    input  logic                pulse_clk,
    input  logic                sys_rst_l,
    circle_interp_gen_if.slave  bus
);
    localparam int XW = COORD_W + 1;
    localparam int FW = 2 * COORD_W + 3;
    localparam int CW = COORD_W + 3;

    localparam logic [2:0] c_idle = 3'd0;
    localparam logic [2:0] c_load = 3'd1;
    localparam logic [2:0] c_step = 3'd2;
    localparam logic [2:0] c_gap  = 3'd3;
    localparam logic [2:0] c_done = 3'd4;

    localparam logic [CW-1:0]        c_step_limit = {1'b0, {(CW-1){1'b1}}};
    localparam logic [CW-1:0]        c_cnt_one    = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [DIV_W-1:0]     c_div_one    = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam logic signed [FW-1:0] c_f_one      = {{(FW-1){1'b0}}, 1'b1};

    logic [2:0]              r_state, w_next;
    logic signed [XW-1:0]    r_x, r_y, r_xe, r_ye;
    logic signed [FW-1:0]    r_f;
    logic                    r_dir;
    logic [DIV_W-1:0]        r_div, r_gap;
    logic [CW-1:0]           r_step_cnt;
    logic [1:0]              r_status;
    logic                    r_x_acc, r_x_dec, r_y_acc, r_y_dec;

    logic                    w_last_gap, w_end_hit, w_limit_hit;
    logic                    w_dx_nz, w_dx_neg, w_dy_nz, w_dy_neg;
    logic                    w_x_red, w_take_x, w_take_y, w_s_neg;
    logic signed [XW-1:0]    w_coord, w_delta;
    logic signed [FW-1:0]    w_coord2, w_f_step;

    assign w_last_gap  = (r_gap == '0);
    assign w_end_hit   = (r_x == r_xe) && (r_y == r_ye);
    assign w_limit_hit = (r_step_cnt == c_step_limit);

    // Tangent candidates: CW (sign(y), -sign(x)), CCW (-sign(y), sign(x)).
    assign w_dx_nz  = (r_y != '0);
    assign w_dy_nz  = (r_x != '0);
    assign w_dx_neg = r_dir ? r_y[XW-1] : (!r_y[XW-1] && w_dx_nz);
    assign w_dy_neg = r_dir ? (!r_x[XW-1] && w_dy_nz) : r_x[XW-1];
    assign w_x_red  = (w_dx_neg != r_x[XW-1]);

    // F >= 0 picks the magnitude-reducing move, F < 0 the increasing one.
    assign w_take_x = w_dx_nz && (!w_dy_nz || ((!r_f[FW-1]) == w_x_red));
    assign w_take_y = !w_take_x && w_dy_nz;
    assign w_s_neg  = w_take_x ? w_dx_neg : w_dy_neg;
    assign w_coord  = w_take_x ? r_x : r_y;
    assign w_delta  = {{(XW-1){w_s_neg}}, 1'b1};
    assign w_coord2 = {{(FW-XW-1){w_coord[XW-1]}}, w_coord, 1'b0};
    assign w_f_step = w_s_neg ? (r_f - w_coord2 + c_f_one) : (r_f + w_coord2 + c_f_one);

    always_ff @(posedge pulse_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) r_state <= c_idle;
        else            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_idle: if (bus.start) w_next = c_load;
            c_load: w_next = bus.abort ? c_done : c_step;
            c_step: w_next = bus.abort ? c_done : c_gap;
            c_gap: begin
                if (bus.abort)
                    w_next = c_done;
                else if (w_last_gap)
                    w_next = (w_end_hit || w_limit_hit) ? c_done : c_step;
            end
            c_done:  w_next = c_idle;
            default: w_next = c_idle;
        endcase
    end

    always_ff @(posedge pulse_clk or negedge sys_rst_l) begin
        if (!sys_rst_l) begin
            r_x        <= '0;
            r_y        <= '0;
            r_xe       <= '0;
            r_ye       <= '0;
            r_f        <= '0;
            r_dir      <= 1'b0;
            r_div      <= '0;
            r_gap      <= '0;
            r_step_cnt <= '0;
            r_status   <= 2'b00;
            r_x_acc    <= 1'b0;
            r_x_dec    <= 1'b0;
            r_y_acc    <= 1'b0;
            r_y_dec    <= 1'b0;
        end else begin
            r_x_acc <= 1'b0;
            r_x_dec <= 1'b0;
            r_y_acc <= 1'b0;
            r_y_dec <= 1'b0;
            case (r_state)
                c_load: begin
                    r_x        <= {bus.Xs[COORD_W-1], bus.Xs};
                    r_y        <= {bus.Ys[COORD_W-1], bus.Ys};
                    r_xe       <= {bus.Xe[COORD_W-1], bus.Xe};
                    r_ye       <= {bus.Ye[COORD_W-1], bus.Ye};
                    r_dir      <= bus.direct;
                    r_div      <= bus.div;
                    r_f        <= '0;
                    r_step_cnt <= '0;
                    r_status   <= bus.abort ? 2'b01 : 2'b00;
                end
                c_step: begin
                    if (bus.abort) begin
                        r_status <= 2'b01;
                    end else begin
                        if (w_take_x) r_x <= r_x + w_delta;
                        if (w_take_y) r_y <= r_y + w_delta;
                        if (w_take_x || w_take_y) r_f <= w_f_step;
                        r_step_cnt <= r_step_cnt + c_cnt_one;
                        r_x_acc    <= w_take_x && !w_s_neg;
                        r_x_dec    <= w_take_x && w_s_neg;
                        r_y_acc    <= w_take_y && !w_s_neg;
                        r_y_dec    <= w_take_y && w_s_neg;
                        r_gap      <= (r_div == '0) ? '0 : (r_div - c_div_one);
                    end
                end
                c_gap: begin
                    if (bus.abort)
                        r_status <= 2'b01;
                    else if (!w_last_gap)
                        r_gap <= r_gap - c_div_one;
                    else if (!w_end_hit && w_limit_hit)
                        r_status <= 2'b10;
                end
                default: ;
            endcase
        end
    end

    assign bus.X_acc       = r_x_acc;
    assign bus.X_dec       = r_x_dec;
    assign bus.Y_acc       = r_y_acc;
    assign bus.Y_dec       = r_y_dec;
    assign bus.busy        = (r_state == c_load) || (r_state == c_step) || (r_state == c_gap);
    assign bus.draw_overH  = (r_state == c_done);
    assign bus.done_status = r_status;
    assign bus.step_cnt    = r_step_cnt;
endmodule
`default_nettype wire

// File: tb/tb_circle_interp_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_circle_interp_gen
//  Brief    : Directed vector bench for circle_interp_gen (16-bit and 6-bit).
//  Revision : 1.0
// ============================================================================
module tb_circle_interp_gen;
    logic pulse_clk = 1'b0;
    logic sys_rst_l;
    always #5 pulse_clk = ~pulse_clk;

    circle_interp_gen_if #(.COORD_W(16), .DIV_W(8)) bus16 ();
    circle_interp_gen_if #(.COORD_W(6),  .DIV_W(8)) bus6 ();

    circle_interp_gen #(.COORD_W(16), .DIV_W(8)) dut16 (
        .pulse_clk (pulse_clk),
        .sys_rst_l (sys_rst_l),
        .bus       (bus16)
    );
    circle_interp_gen #(.COORD_W(6), .DIV_W(8)) dut6 (
        .pulse_clk (pulse_clk),
        .sys_rst_l (sys_rst_l),
        .bus       (bus6)
    );

    logic       r_start, r_dir, r_abort, r_sel;
    logic [7:0] r_div;
    int         r_xs, r_ys, r_xe, r_ye;

    assign bus16.start  = r_start & ~r_sel;
    assign bus6.start   = r_start & r_sel;
    assign bus16.direct = r_dir;
    assign bus6.direct  = r_dir;
    assign bus16.abort  = r_abort;
    assign bus6.abort   = r_abort;
    assign bus16.div    = r_div;
    assign bus6.div     = r_div;
    assign bus16.Xs = r_xs[15:0];
    assign bus16.Ys = r_ys[15:0];
    assign bus16.Xe = r_xe[15:0];
    assign bus16.Ye = r_ye[15:0];
    assign bus6.Xs  = r_xs[5:0];
    assign bus6.Ys  = r_ys[5:0];
    assign bus6.Xe  = r_xe[5:0];
    assign bus6.Ye  = r_ye[5:0];

    // Pulse code: 8=X_acc, 4=X_dec, 2=Y_acc, 1=Y_dec.
    logic [3:0]  w_p;
    logic        w_dov, w_busy;
    logic [1:0]  w_st;
    logic [31:0] w_cnt;
    assign w_p    = r_sel ? {bus6.X_acc, bus6.X_dec, bus6.Y_acc, bus6.Y_dec}
                          : {bus16.X_acc, bus16.X_dec, bus16.Y_acc, bus16.Y_dec};
    assign w_dov  = r_sel ? bus6.draw_overH : bus16.draw_overH;
    assign w_busy = r_sel ? bus6.busy : bus16.busy;
    assign w_st   = r_sel ? bus6.done_status : bus16.done_status;
    assign w_cnt  = r_sel ? 32'(bus6.step_cnt) : 32'(bus16.step_cnt);

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    typedef struct {
        bit sel; int dv; bit dir;
        int xs; int ys; int xe; int ye;
        int abort_cyc; int first_code;
        int n_xa; int n_xd; int n_ya; int n_yd;
        int total; int period; int done_cyc; int status; int cnt;
    } vec_t;

    vec_t tbl[7];

    // Called at a falling edge; start is sampled on the next rising edge.
    task automatic run_case(input int idx, input vec_t v);
        int n_pul = 0, first_code = -1, first_cyc = -1, last_cyc = -1;
        int done_at = -1, n_dov = 0, n_after = 0, bad_gap = 0, bad_hot = 0;
        int cnt[4] = '{0, 0, 0, 0};
        string tag;
        tag = $sformatf("case%0d", idx);
        r_sel = v.sel; r_dir = v.dir; r_div = 8'(v.dv);
        r_xs = v.xs; r_ys = v.ys; r_xe = v.xe; r_ye = v.ye;
        r_abort = 1'b0;
        r_start = 1'b1;
        @(negedge pulse_clk);
        r_start = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            r_abort = (c == v.abort_cyc);
            if (w_p != 4'b0000) begin
                if (!$onehot(w_p)) bad_hot++;
                if (done_at >= 0) n_after++;
                n_pul++;
                for (int b = 0; b < 4; b++) if (w_p[b]) cnt[b]++;
                if (first_cyc < 0) begin
                    first_cyc  = c;
                    first_code = int'(w_p);
                end else if (c - last_cyc != v.period) begin
                    bad_gap++;
                end
                last_cyc = c;
            end
            if (w_dov) begin
                n_dov++;
                if (done_at < 0) done_at = c;
            end
            if (done_at >= 0 && c >= done_at + 3) break;
            @(negedge pulse_clk);
        end
        r_abort = 1'b0;
        chk({tag, "_done_cycle"}, done_at, v.done_cyc);
        chk({tag, "_first_latency"}, first_cyc, 2);
        chk({tag, "_first_code"}, first_code, v.first_code);
        chk({tag, "_pulses"}, n_pul, v.total);
        if (v.n_xa >= 0) begin
            chk({tag, "_x_acc"}, cnt[3], v.n_xa);
            chk({tag, "_x_dec"}, cnt[2], v.n_xd);
            chk({tag, "_y_acc"}, cnt[1], v.n_ya);
            chk({tag, "_y_dec"}, cnt[0], v.n_yd);
        end
        chk({tag, "_bad_spacing"}, bad_gap, 0);
        chk({tag, "_not_onehot"}, bad_hot, 0);
        chk({tag, "_draw_over_count"}, n_dov, 1);
        chk({tag, "_pulses_after_done"}, n_after, 0);
        chk({tag, "_status"}, int'(w_st), v.status);
        chk({tag, "_step_cnt"}, int'(w_cnt), v.cnt);
        chk({tag, "_busy_after"}, int'(w_busy), 0);
    endtask

    initial begin
        //          sel dv dir  xs  ys  xe  ye  ab  fc  xa xd ya yd tot per done st cnt
        tbl[0] = '{0, 0, 0,  5,  0,  0,  5, -1, 2,  0, 5, 5, 0, 10, 2, 21,  0, 10};
        tbl[1] = '{0, 0, 1,  4,  0,  4,  0, -1, 1,  8, 8, 8, 8, 32, 2, 65,  0, 32};
        tbl[2] = '{0, 3, 0,  3,  0,  0,  3, -1, 2,  0, 3, 3, 0,  6, 4, 25,  0,  6};
        tbl[3] = '{0, 0, 0,  5,  0,  0,  5,  7, 2,  0, 1, 2, 0,  3, 2,  8,  1,  3};
        tbl[4] = '{0, 1, 1,  0,  3,  3,  0, -1, 8,  3, 0, 0, 3,  6, 2, 13,  0,  6};
        tbl[5] = '{0, 2, 0,  0, -2,  0,  2, -1, 8,  2, 2, 4, 0,  8, 3, 25,  0,  8};
        tbl[6] = '{1, 0, 0,  3,  0,  1,  1, -1, 2, -1,-1,-1,-1,255, 2, 511, 2, 255};

        sys_rst_l = 1'b0;
        r_start = 1'b0; r_dir = 1'b0; r_abort = 1'b0; r_sel = 1'b0; r_div = 8'd0;
        r_xs = 0; r_ys = 0; r_xe = 0; r_ye = 0;
        repeat (3) @(negedge pulse_clk);
        chk("reset_pulses", int'(w_p), 0);
        chk("reset_busy", int'(w_busy), 0);
        chk("reset_draw_over", int'(w_dov), 0);
        chk("reset_status", int'(w_st), 0);
        chk("reset_step_cnt", int'(w_cnt), 0);
        sys_rst_l = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_case(i, tbl[i]);
            @(negedge pulse_clk);
        end

        // Reset in the middle of a run, away from any clock edge.
        begin
            int leak = 0;
            r_sel = 1'b0; r_dir = 1'b0; r_div = 8'd0;
            r_xs = 5; r_ys = 0; r_xe = 0; r_ye = 5;
            r_start = 1'b1;
            @(negedge pulse_clk);
            r_start = 1'b0;
            repeat (6) @(negedge pulse_clk);
            chk("midrun_busy_before", int'(w_busy), 1);
            #2 sys_rst_l = 1'b0;
            #1;
            chk("midrun_rst_pulses", int'(w_p), 0);
            chk("midrun_rst_busy", int'(w_busy), 0);
            chk("midrun_rst_draw_over", int'(w_dov), 0);
            chk("midrun_rst_status", int'(w_st), 0);
            chk("midrun_rst_step_cnt", int'(w_cnt), 0);
            for (int k = 0; k < 4; k++) begin
                @(negedge pulse_clk);
                if (w_p != 4'b0000 || w_busy) leak++;
            end
            chk("midrun_rst_activity", leak, 0);
            sys_rst_l = 1'b1;
            run_case(7, tbl[0]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/circle_interp_gen.md
CIRCLE_INTERP_GEN -- requirements
Module: circle_interp_gen

Interface
REQ-001 SHALL have parameter COORD_W, default 16, meaning signed coordinate width.
REQ-002 SHALL have parameter DIV_W, default 8, meaning step-gap divider width.
REQ-003 SHALL have port pulse_clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port sys_rst_l, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have inputs start (1, run request), direct (1; 1=clockwise, 0=counter-clockwise) and abort (1, stop request).
REQ-006 SHALL have inputs Xs, Ys, Xe, Ye (signed COORD_W each, start/end points, centre at origin) and div (DIV_W, gap cycles between steps).
REQ-007 SHALL have outputs X_acc, X_dec, Y_acc, Y_dec (1 each, registered one-cycle step pulses).
REQ-008 SHALL have outputs busy (1), draw_overH (1, run-finished strobe), done_status (2; 00 end reached, 01 aborted, 10 step limit) and step_cnt (COORD_W+3, steps issued).

Function
REQ-009 SHALL implement FSM states IDLE, LOAD, STEP, GAP, DONE.
REQ-010 IDLE: SHALL hold busy=0 and go to LOAD when start=1 is sampled.
REQ-011 LOAD (1 cycle): SHALL latch Xs, Ys, Xe, Ye and direct; set x=Xs, y=Ys, error F=0, step_cnt=0; busy=1; go to STEP.
REQ-012 SHALL ignore start while busy=1 and ignore input changes after LOAD.
REQ-013 STEP (1 cycle): SHALL select candidate moves CW dx=sign(y), dy=-sign(x); CCW dx=-sign(y), dy=sign(x).
REQ-014 If exactly one candidate is nonzero (point on an axis), SHALL take it regardless of F.
REQ-015 Otherwise SHALL take the candidate reducing |coordinate| when F>=0 and the candidate increasing |coordinate| when F<0.
REQ-016 An x step of s SHALL update F=F+2*s*x+1 with old x, then x=x+s; y steps likewise; step_cnt SHALL increment.
REQ-017 F SHALL be signed 2*COORD_W+3 bits and x, y signed COORD_W+1 bits, so no intermediate overflows.
REQ-018 Exactly one of X_acc (s=+1 on x), X_dec, Y_acc, Y_dec SHALL be high for the one cycle after the STEP edge; all SHALL be 0 otherwise.
REQ-019 GAP SHALL last max(div,1) cycles; the step period SHALL be max(div,1)+1 cycles.
REQ-020 On the last GAP cycle SHALL go to DONE with status 00 if (x,y)==(Xe,Ye), otherwise return to STEP.
REQ-021 The end-point check SHALL occur only after a step, so Xs==Xe and Ys==Ye runs a full circle.
REQ-022 If step_cnt reaches 2^(COORD_W+2)-1 without an end match, SHALL go to DONE with status 10.
REQ-023 abort=1 in LOAD, STEP or GAP SHALL go to DONE with status 01; abort in STEP SHALL suppress that step's pulse and updates.
REQ-024 DONE (1 cycle): SHALL drive draw_overH=1, busy=0, and return to IDLE.
REQ-025 done_status and step_cnt SHALL hold until the next LOAD.
REQ-026 Latency: start sampled at edge k SHALL give the first pulse high after edge k+2.
REQ-027 Inputs SHALL satisfy |coord| <= 2^(COORD_W-1)-1; other values are undefined.

Reset
REQ-028 sys_rst_l=0 SHALL immediately force IDLE, all pulses 0, busy=0, draw_overH=0, done_status=00, step_cnt=0 and F=0.
REQ-029 Reset mid-run SHALL drop the run with no further pulses; start SHALL be accepted on the first edge after release.

Verification
REQ-030 COORD_W=16, div=0, direct=0, (5,0)->(0,5): first pulse Y_acc, 5 Y_acc + 5 X_dec, one pulse per 2 cycles, draw_overH once, status 00, step_cnt=10.
REQ-031 direct=1, (4,0)->(4,0): first pulse Y_dec, 32 pulses, return to (4,0), status 00, step_cnt=32.
REQ-032 div=3, (3,0)->(0,3) CCW: pulses spaced exactly 4 cycles, 6 pulses total.
REQ-033 abort=1 on the STEP cycle after 3 pulses: no 4th pulse, draw_overH one cycle later, status 01, step_cnt=3.
REQ-034 COORD_W=6, (3,0)->(1,1): no end match, exactly 255 pulses, status 10.
REQ-035 sys_rst_l low mid-run: all outputs 0 with no clock edge, busy=0; after release, start runs the REQ-030 case correctly.
